mem_arbiter: RTL and testbench

Shared main-memory front end that sits directly downstream of the I-cache and D-cache fill FSMs. It arbitrates the two cache-side requesters onto one pipelined, fixed-latency word memory: block fills hold exclusive ownership, and single-word D-cache write-through stores are slotted in when memory is free. Read data returns exactly LATENCY cycles after issue, tagged to the requester that issued it.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_pipe4c.sv | 64 ++++++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory arbiter slice.
//   - default address/data widths, read latency and memory depth
//   - owner_e: bus-owner encoding, used both as the arbiter state and as
//     the tag carried by every in-flight read (OWN_NONE doubles as IDLE)
package mem_pkg;

    localparam int unsigned ADDR_W_DEF         = 16;
    localparam int unsigned DATA_W_DEF         = 16;
    localparam int unsigned LATENCY_DEF        = 4;
    localparam int unsigned MEM_WORDS_LOG2_DEF = 15;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side request/return bundle of the memory arbiter.
//   master modport: the cache fill FSMs (drive requests, receive grants/data)
//   slave  modport: the arbiter
//   I side : i_req, i_rd, i_addr -> ; <- i_grant, i_data_valid
//   D side : d_req, d_rd, d_addr, d_wr, d_wdata -> ; <- d_grant, d_data_valid, d_wr_done
//   shared : <- rd_data
interface mem_arbiter_if
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              i_req;
    logic              i_rd;
    logic [ADDR_W-1:0] i_addr;
    logic              i_grant;
    logic              i_data_valid;

    logic              d_req;
    logic              d_rd;
    logic [ADDR_W-1:0] d_addr;
    logic              d_wr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_grant;
    logic              d_data_valid;
    logic              d_wr_done;

    logic [DATA_W-1:0] rd_data;

    modport master (
        output i_req, i_rd, i_addr,
        output d_req, d_rd, d_addr, d_wr, d_wdata,
        input  i_grant, i_data_valid,
        input  d_grant, d_data_valid, d_wr_done,
        input  rd_data
    );

    modport slave (
        input  i_req, i_rd, i_addr,
        input  d_req, d_rd, d_addr, d_wr, d_wdata,
        output i_grant, i_data_valid,
        output d_grant, d_data_valid, d_wr_done,
        output rd_data
    );

endinterface

// File: rtl/mem_pipe4c.sv
// mem_pipe4c: word memory with one write port and a fully pipelined,
// fixed-latency read port.
//   clk, rst            : clock, synchronous active-high reset (pipeline only)
//   wr_en/wr_word/wr_data : single-word write, memory updated at the clock edge
//   rd_en/rd_word/rd_tag  : read issue; data and tag emerge LATENCY cycles later
//   ret_valid/ret_tag/ret_data : pipeline tail
// Memory contents are never reset.
module mem_pipe4c
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned LATENCY        = LATENCY_DEF,
    parameter int unsigned MEM_WORDS_LOG2 = MEM_WORDS_LOG2_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [MEM_WORDS_LOG2-1:0] wr_word,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    input  logic [MEM_WORDS_LOG2-1:0] rd_word,
    input  owner_e                    rd_tag,
    output logic                      ret_valid,
    output owner_e                    ret_tag,
    output logic [DATA_W-1:0]         ret_data
);

    typedef struct packed {
        logic              valid;
        owner_e            tag;
        logic [DATA_W-1:0] data;
    } stage_t;

    logic [DATA_W-1:0] mem [2**MEM_WORDS_LOG2];
    stage_t            pipe [LATENCY];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_word] <= wr_data;
        end
    end

    // The array is read at issue time, so stage 0 already holds the data;
    // the remaining stages only delay it to the fixed return slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= rd_en;
            pipe[0].tag   <= rd_tag;
            pipe[0].data  <= mem[rd_word];
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign ret_valid = pipe[LATENCY-1].valid;
    assign ret_tag   = pipe[LATENCY-1].tag;
    assign ret_data  = pipe[LATENCY-1].data;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the I-cache and D-cache fill FSMs onto one
// pipelined word memory.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave (requests in, grants/returns out)
// Block fills own the memory exclusively until their req drops; D-side
// single-word writes are taken only while nobody owns the memory. Read
// returns are tagged with the issuing owner and dropped if ownership has
// moved on by the time they come back.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned LATENCY        = LATENCY_DEF,
    parameter int unsigned MEM_WORDS_LOG2 = MEM_WORDS_LOG2_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    // OWN_NONE is the IDLE state.
    owner_e state_q;
    owner_e state_d;
    logic   wr_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_grant = 1'b0;
        case (state_q)
            OWN_NONE: begin
                if (bus.d_wr) begin
                    wr_grant = 1'b1;
                end else if (bus.d_req) begin
                    state_d = OWN_D;
                end else if (bus.i_req) begin
                    state_d = OWN_I;
                end
            end
            OWN_I: begin
                if (!bus.i_req) begin
                    state_d = OWN_NONE;
                end
            end
            OWN_D: begin
                if (!bus.d_req) begin
                    state_d = OWN_NONE;
                end
            end
            default: begin
                state_d = OWN_NONE;
            end
        endcase
    end

    // Issue / write muxing
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              unused_addr_lsb;

    assign wr_en   = wr_grant && !rst;
    assign rd_en   = !rst && (((state_q == OWN_I) && bus.i_rd) ||
                              ((state_q == OWN_D) && bus.d_rd));
    assign rd_addr = (state_q == OWN_I) ? bus.i_addr : bus.d_addr;
    assign unused_addr_lsb = rd_addr[0];

    logic              ret_valid;
    owner_e            ret_tag;
    logic [DATA_W-1:0] ret_data;

    mem_pipe4c #(
        .DATA_W         (DATA_W),
        .LATENCY        (LATENCY),
        .MEM_WORDS_LOG2 (MEM_WORDS_LOG2)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_word   (bus.d_addr[MEM_WORDS_LOG2:1]),
        .wr_data   (bus.d_wdata),
        .rd_en     (rd_en),
        .rd_word   (rd_addr[MEM_WORDS_LOG2:1]),
        .rd_tag    (state_q),
        .ret_valid (ret_valid),
        .ret_tag   (ret_tag),
        .ret_data  (ret_data)
    );

    // Return steering: a return is only delivered to its issuer while that
    // issuer still owns the memory. Returns are never tagged OWN_NONE, so
    // anything arriving in IDLE is squashed too.
    logic              deliver;
    logic [DATA_W-1:0] rd_data_q;

    assign deliver = ret_valid && (ret_tag == state_q) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (deliver) begin
            rd_data_q <= ret_data;
        end
    end

    assign bus.i_grant      = (state_q == OWN_I);
    assign bus.d_grant      = (state_q == OWN_D);
    assign bus.i_data_valid = deliver && (ret_tag == OWN_I);
    assign bus.d_data_valid = deliver && (ret_tag == OWN_D);
    assign bus.d_wr_done    = wr_en;
    assign bus.rd_data      = deliver ? ret_data : rd_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized phase, checked every
// cycle against a behavioural model (owner variable, word map, queue of
// pending returns), with literal expectations pinning key cycles.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(
        .ADDR_W         (16),
        .DATA_W         (16),
        .LATENCY        (LAT),
        .MEM_WORDS_LOG2 (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        int          tag;   // 1 = I, 2 = D
        logic [15:0] data;
    } ret_t;

    ret_t        pend[$];
    logic [15:0] mem_m [int];
    int          owner_m = 0;   // 0 none, 1 I, 2 D
    logic [15:0] last_m  = '0;
    int          cyc     = 0;
    bit          model_on = 1'b0;

    bit          e_iv, e_dv, e_wd;
    logic [15:0] e_rd;
    ret_t        r;

    function automatic logic [15:0] rd_mem(input logic [15:0] a);
        int k;
        k = int'(a >> 1);
        if (mem_m.exists(k)) return mem_m[k];
        return 'x;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (model_on) begin
                check("rst_i_valid", bus.i_data_valid, 0);
                check("rst_d_valid", bus.d_data_valid, 0);
                check("rst_wr_done", bus.d_wr_done, 0);
            end
            model_on = 1'b1;
            owner_m  = 0;
            pend.delete();
            last_m   = '0;
        end else if (model_on) begin
            e_iv = 1'b0;
            e_dv = 1'b0;
            e_rd = last_m;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                if (pend[0].tag == owner_m) begin
                    e_iv = (pend[0].tag == 1);
                    e_dv = (pend[0].tag == 2);
                    e_rd = pend[0].data;
                end
                void'(pend.pop_front());
            end
            e_wd = (owner_m == 0) && bus.d_wr;

            check("cmp_i_grant", bus.i_grant, owner_m == 1);
            check("cmp_d_grant", bus.d_grant, owner_m == 2);
            check("cmp_i_valid", bus.i_data_valid, e_iv);
            check("cmp_d_valid", bus.d_data_valid, e_dv);
            check("cmp_wr_done", bus.d_wr_done, e_wd);
            check("cmp_rd_data", bus.rd_data, e_rd);
            last_m = e_rd;

            if (owner_m == 1 && bus.i_rd) begin
                r.due = cyc + LAT; r.tag = 1; r.data = rd_mem(bus.i_addr);
                pend.push_back(r);
            end
            if (owner_m == 2 && bus.d_rd) begin
                r.due = cyc + LAT; r.tag = 2; r.data = rd_mem(bus.d_addr);
                pend.push_back(r);
            end
            if (e_wd) mem_m[int'(bus.d_addr >> 1)] = bus.d_wdata;

            case (owner_m)
                0:       owner_m = bus.d_wr ? 0 : bus.d_req ? 2 : bus.i_req ? 1 : 0;
                1:       owner_m = bus.i_req ? 1 : 0;
                default: owner_m = bus.d_req ? 2 : 0;
            endcase
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        #3;
    endtask

    task automatic clr();
        bus.i_req = 0; bus.i_rd = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_rd = 0; bus.d_addr = '0;
        bus.d_wr  = 0; bus.d_wdata = '0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit pin);
        bus.d_wr = 1; bus.d_addr = a; bus.d_wdata = d;
        if (pin) begin
            peek();
            check("wr_done_idle", bus.d_wr_done, 1);
        end
        tick();
        bus.d_wr = 0;
    endtask

    initial begin
        clr();
        rst = 1;
        repeat (2) tick();
        rst = 0;

        // Reset state over 8 idle cycles
        for (int c = 0; c < 8; c++) begin
            peek();
            check("reset_flags", {bus.i_grant, bus.d_grant, bus.i_data_valid,
                                  bus.d_data_valid, bus.d_wr_done}, 0);
            check("reset_rd_data", bus.rd_data, 0);
            tick();
        end

        // Preload through the write port
        for (int w = 0; w < 64; w++) wr(16'(2 * w), 16'hC000 | 16'(2 * w), 1'b0);
        wr(16'hFFF0, 16'h0001, 1'b1);
        wr(16'h0040, 16'hBEEF, 1'b1);

        // D fill reads back the written word
        bus.d_req = 1; tick();
        bus.d_rd = 1; bus.d_addr = 16'h0040; peek();
        check("d_grant_c1", bus.d_grant, 1);
        tick();
        bus.d_rd = 0; repeat (3) tick();
        peek();
        check("wr_readback_valid", bus.d_data_valid, 1);
        check("wr_readback_data", bus.rd_data, 16'hBEEF);
        tick(); bus.d_req = 0; tick();

        // Single I fill
        bus.i_req = 1; tick();
        bus.i_rd = 1; bus.i_addr = 16'hFFF0; peek();
        check("i_grant_c1", bus.i_grant, 1);
        tick();
        bus.i_rd = 0; repeat (3) tick();
        peek();
        check("i_fill_valid", bus.i_data_valid, 1);
        check("i_fill_data", bus.rd_data, 16'h0001);
        check("i_fill_no_d", bus.d_data_valid, 0);
        tick(); bus.i_req = 0; tick();

        // Contention: D wins, I granted two cycles after d_req drops
        bus.i_req = 1; bus.d_req = 1; tick();
        peek();
        check("cont_d_grant", bus.d_grant, 1);
        check("cont_i_wait", bus.i_grant, 0);
        repeat (9) tick();
        bus.d_req = 0; tick();
        peek(); check("cont_gap_c11", bus.i_grant, 0); tick();
        peek(); check("cont_i_grant_c12", bus.i_grant, 1); tick();
        bus.i_req = 0; tick();

        // Pipelined 8-word D block
        bus.d_req = 1; tick();
        for (int c = 1; c <= 13; c++) begin
            bus.d_rd = (c <= 8);
            bus.d_addr = 16'h0020 + 16'(2 * (c - 1));
            if (c == 13) bus.d_req = 0;
            peek();
            if (c >= 4) check("blk_valid", bus.d_data_valid, (c >= 5 && c <= 12));
            if (c >= 5 && c <= 12)
                check("blk_data", bus.rd_data, 16'hC000 | (16'h0020 + 16'(2 * (c - 5))));
            tick();
        end
        bus.d_rd = 0;

        // Write held off during I ownership
        bus.i_req = 1; tick();
        tick(); tick();
        bus.d_wr = 1; bus.d_addr = 16'h0042; bus.d_wdata = 16'h1234; peek();
        check("wr_held_c3", bus.d_wr_done, 0);
        tick(); tick();
        bus.i_req = 0; peek();
        check("wr_held_c5", bus.d_wr_done, 0);
        tick();
        peek(); check("wr_done_after_release", bus.d_wr_done, 1);
        tick(); bus.d_wr = 0;

        // Abort: I return squashed after D takes over
        bus.i_req = 1; tick();
        bus.i_rd = 1; bus.i_addr = 16'h0010; tick();
        bus.i_rd = 0; bus.i_req = 0; bus.d_req = 1; tick();
        tick();
        for (int c = 4; c <= 8; c++) begin
            peek();
            if (c == 4) check("abort_d_grant", bus.d_grant, 1);
            check("abort_squash", {bus.i_data_valid, bus.d_data_valid}, 0);
            tick();
        end
        bus.d_req = 0; tick();

        // Reset two cycles after a read issue
        bus.d_req = 1; tick();
        bus.d_rd = 1; bus.d_addr = 16'h0012; tick();
        bus.d_rd = 0; tick();
        rst = 1; bus.d_req = 0; tick();
        rst = 0;
        for (int c = 4; c <= 11; c++) begin
            peek();
            check("rst_drop", {bus.i_data_valid, bus.d_data_valid}, 0);
            tick();
        end

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) bus.i_req = ~bus.i_req;
            if ($urandom_range(0, 7) == 0) bus.d_req = ~bus.d_req;
            bus.i_rd    = 1'($urandom_range(0, 1));
            bus.d_rd    = 1'($urandom_range(0, 1));
            bus.i_addr  = 16'($urandom_range(0, 127));
            bus.d_addr  = 16'($urandom_range(0, 127));
            bus.d_wr    = ($urandom_range(0, 5) == 0);
            bus.d_wdata = 16'($urandom);
            rst         = ($urandom_range(0, 299) == 0);
            tick();
        end

        clr();
        rst = 0;
        repeat (LAT + 2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
